// File: rtl/pb_axi_burst_master.sv
// rtl/pb_axi_burst_master.sv - single-outstanding AXI4 INCR burst initiator
// One command launches one read or write burst; write/read data pass straight through to W/R.
module pb_axi_burst_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic              done,
   output logic [1:0]        done_resp,
   output logic              done_err,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [7:0]        m_axi_awlen,
   output logic [2:0]        m_axi_awsize,
   output logic [1:0]        m_axi_awburst,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wlast,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   localparam logic [8:0]        MAX_LEN_LIM = 9'(MAX_BEATS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK  = {{(ADDR_W-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        beat_cnt;
   logic [1:0]        resp_q;
   logic              err_q;

   logic        accept, reject, w_fire, r_fire, r_at_len, r_end;
   logic [13:0] end_byte;

   // One past the last byte of the burst, relative to the 4KB page start.
   assign end_byte = {2'b00, cmd_addr[11:2], 2'b00} + {4'd0, cmd_len, 2'b00} + 14'd4;
   assign reject   = ({1'b0, cmd_len} >= MAX_LEN_LIM) | (end_byte > 14'd4096);
   assign accept   = cmd_valid & cmd_ready;
   assign w_fire   = (state == S_W) & wr_valid & m_axi_wready;
   assign r_fire   = (state == S_R) & m_axi_rvalid & rd_ready;
   assign r_at_len = (beat_cnt == len_q);
   assign r_end    = r_fire & (m_axi_rlast | r_at_len);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = reject ? S_DONE : (cmd_write ? S_AW : S_AR);
         S_AW:   if (m_axi_awready) state_nxt = S_W;
         S_W:    if (w_fire && (beat_cnt == len_q)) state_nxt = S_B;
         S_B:    if (m_axi_bvalid) state_nxt = S_DONE;
         S_AR:   if (m_axi_arready) state_nxt = S_R;
         S_R:    if (r_end) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      wr_ready      = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_rready  = 1'b0;
      rd_valid      = 1'b0;
      rd_last       = 1'b0;
      done          = 1'b0;
      case (state)
         S_IDLE: cmd_ready = 1'b1;
         S_AW:   m_axi_awvalid = 1'b1;
         S_W: begin
            m_axi_wvalid = wr_valid;
            m_axi_wlast  = (beat_cnt == len_q);
            wr_ready     = m_axi_wready;
         end
         S_B:    m_axi_bready = 1'b1;
         S_AR:   m_axi_arvalid = 1'b1;
         S_R: begin
            m_axi_rready = rd_ready;
            rd_valid     = m_axi_rvalid;
            rd_last      = m_axi_rlast;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         resp_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= cmd_addr & ALIGN_MASK;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            resp_q   <= reject ? 2'b10 : 2'b00;
            err_q    <= reject;
         end
         if (w_fire) beat_cnt <= beat_cnt + 8'd1;
         if ((state == S_B) && m_axi_bvalid) resp_q <= m_axi_bresp;
         if (r_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_axi_rresp > resp_q) resp_q <= m_axi_rresp;
            // Slave's RLAST and our own beat count must agree on the final beat.
            if (r_end && (m_axi_rlast != r_at_len)) err_q <= 1'b1;
         end
      end
   end

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = 3'b010;
   assign m_axi_awburst = 2'b01;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = 3'b010;
   assign m_axi_arburst = 2'b01;
   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = 4'hF;
   assign rd_data       = m_axi_rdata;
   assign done_resp     = resp_q;
   assign done_err      = err_q;

endmodule

// File: tb/tb_pb_axi_burst_master.sv
// tb/tb_pb_axi_burst_master.sv - self-checking bench for pb_axi_burst_master
// Directed vector table plus random commands scored against a spec-level outcome model.
module tb_pb_axi_burst_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, rd_ready;
   logic        done, done_err;
   logic [1:0]  done_resp;
   logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   always #5 clk = ~clk;

   pb_axi_burst_master #(.ADDR_W(32), .DATA_W(32), .MAX_BEATS(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp), .done_err(done_err),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // rlast_at: -1 = RLAST on beat len, -2 = never, k = RLAST on beat k
   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [7:0]  len;
      int          rlast_at;
      logic [1:0]  bresp;
      logic        rresp_rand;
      int          stall;
      int          reset_at;
      logic [31:0] dbase;
      logic        exp_rej;
      logic [1:0]  exp_resp;
      logic        exp_err;
      int          exp_beats;
   } vec_t;

   logic [1:0] rresp_seq [256];
   vec_t       dir [14];

   // Outcome of a command computed from the rules alone: legality, beat count, worst response.
   function automatic vec_t model(input vec_t v);
      vec_t m = v;
      int   base  = int'(v.addr[11:0]) & 32'hFFC;
      int   bytes = (int'(v.len) + 1) * 4;
      int   last;
      m.exp_rej = (int'(v.len) >= 16) || (base + bytes > 4096);
      if (m.exp_rej) begin
         m.exp_resp = 2'b10; m.exp_err = 1'b1; m.exp_beats = 0;
      end else if (v.write) begin
         m.exp_resp = v.bresp; m.exp_err = 1'b0; m.exp_beats = int'(v.len) + 1;
      end else begin
         last = (v.rlast_at == -1) ? int'(v.len) : v.rlast_at;
         m.exp_beats = (last >= 0 && last < int'(v.len)) ? last + 1 : int'(v.len) + 1;
         m.exp_err   = (last != int'(v.len));
         m.exp_resp  = 2'b00;
         for (int k = 0; k < m.exp_beats; k++)
            if (rresp_seq[k] > m.exp_resp) m.exp_resp = rresp_seq[k];
      end
      return m;
   endfunction

   function automatic logic rb(input int stall);
      return (stall == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
   endfunction

   task automatic run(input vec_t v);
      int   cyc = 0, acc_cyc = -1, last_hs = -1, w_cnt = 0, r_cnt = 0;
      int   rlast_idx = (v.rlast_at == -1) ? int'(v.len) : v.rlast_at;
      int   r_total = (rlast_idx >= 0 && rlast_idx <= int'(v.len)) ? rlast_idx + 1 : int'(v.len) + 1;
      bit   accepted = 0, busy, aw_done = 0, ar_done = 0, w_fin = 0, rd_fin = 0, b_done = 0;
      bit   bv = 0, rv = 0, saw_bus = 0, first_av = 0, done_seen = 0, rst_pend = 0;
      while (cyc < 600) begin
         @(posedge clk); #1;
         busy = accepted;
         if (rst_pend) begin
            reset = 1'b1; cmd_valid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0; #1;
            chk("rst_wvalid", {31'd0, m_axi_wvalid}, 0);
            chk("rst_wr_ready", {31'd0, wr_ready}, 0);
            chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_awvalid", {31'd0, m_axi_awvalid}, 0);
            wr_valid = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               chk("rst_no_done", {31'd0, done}, 0);
            end
            return;
         end
         // Requester side: command until accepted, then stray requests while busy.
         if (!accepted) begin
            cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
         end else begin
            cmd_valid = (!done_seen && v.stall != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_write = 1'($urandom_range(0, 1)); cmd_len = 8'($urandom_range(0, 20));
         end
         m_axi_awready = rb(v.stall);
         m_axi_wready  = rb(v.stall);
         wr_valid      = rb(v.stall);
         wr_data       = v.dbase + w_cnt * 32'h11;
         if (w_fin && !b_done && !bv) bv = rb(v.stall);
         m_axi_bvalid  = bv;
         m_axi_bresp   = v.bresp;
         m_axi_arready = rb(v.stall);
         if (ar_done && r_cnt < r_total && !rv) rv = rb(v.stall);
         m_axi_rvalid  = rv;
         m_axi_rdata   = v.dbase + r_cnt * 32'h0101_0101;
         m_axi_rlast   = (r_cnt == rlast_idx);
         m_axi_rresp   = rresp_seq[r_cnt & 255];
         rd_ready      = (v.stall == 0) ? 1'b1 : (v.stall == 2) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         #1;
         if (done_seen) begin
            chk("done_one_cycle", {31'd0, done}, 0);
            chk("cmd_ready_after_done", {31'd0, cmd_ready}, 1);
            chk("done_resp_held", {30'd0, done_resp}, {30'd0, v.exp_resp});
            chk("done_err_held", {31'd0, done_err}, {31'd0, v.exp_err});
            cmd_valid = 1'b0;
            return;
         end
         if (busy) chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
         if (!accepted && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
         if (m_axi_awvalid || m_axi_arvalid) saw_bus = 1;
         if (!first_av && (m_axi_awvalid || m_axi_arvalid)) begin
            first_av = 1;
            chk("addr_valid_latency", cyc - acc_cyc, 1);
            chk("addr_valid_kind", {31'd0, m_axi_awvalid}, {31'd0, v.write});
         end
         if (v.write && accepted && !aw_done)
            chk("no_early_w", {30'd0, m_axi_wvalid, wr_ready}, 0);
         if (v.write && aw_done && !w_fin)
            chk("w_passthru", {30'd0, m_axi_wvalid, wr_ready}, {30'd0, wr_valid, m_axi_wready});
         if (!v.write && ar_done && !rd_fin)
            chk("r_passthru", {30'd0, m_axi_rready, rd_valid}, {30'd0, rd_ready, m_axi_rvalid});
         if (m_axi_awvalid && m_axi_awready) begin
            chk("awaddr", m_axi_awaddr, v.addr & ~32'h3);
            chk("awlen", {24'd0, m_axi_awlen}, {24'd0, v.len});
            chk("aw_const", {27'd0, m_axi_awsize, m_axi_awburst}, {27'd0, 3'b010, 2'b01});
            aw_done = 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            chk("wdata", m_axi_wdata, v.dbase + w_cnt * 32'h11);
            chk("wlast", {31'd0, m_axi_wlast}, {31'd0, w_cnt == int'(v.len)});
            chk("wstrb", {28'd0, m_axi_wstrb}, 32'hF);
            w_cnt++;
            if (w_cnt == int'(v.len) + 1) w_fin = 1;
            if (w_cnt == v.reset_at) rst_pend = 1;
         end
         if (m_axi_bvalid && m_axi_bready) begin b_done = 1; bv = 0; last_hs = cyc; end
         if (m_axi_arvalid && m_axi_arready) begin
            chk("araddr", m_axi_araddr, v.addr & ~32'h3);
            chk("arlen", {24'd0, m_axi_arlen}, {24'd0, v.len});
            chk("ar_const", {27'd0, m_axi_arsize, m_axi_arburst}, {27'd0, 3'b010, 2'b01});
            ar_done = 1;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            chk("rd_data", rd_data, v.dbase + r_cnt * 32'h0101_0101);
            chk("rd_last", {31'd0, rd_last}, {31'd0, r_cnt == rlast_idx});
            r_cnt++; rv = 0;
            if (r_cnt == v.exp_beats) begin rd_fin = 1; last_hs = cyc; end
         end
         if (done) begin
            done_seen = 1;
            chk("done_latency", cyc - (v.exp_rej ? acc_cyc : last_hs), 1);
            chk("done_resp", {30'd0, done_resp}, {30'd0, v.exp_resp});
            chk("done_err", {31'd0, done_err}, {31'd0, v.exp_err});
            chk("beats", v.write ? w_cnt : r_cnt, v.exp_beats);
            if (v.exp_rej) chk("reject_no_bus", {31'd0, saw_bus}, 0);
         end
         cyc++;
      end
      chk("timeout_done_seen", {31'd0, done_seen}, 1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
      wr_data = 0; wr_valid = 0; rd_ready = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;

      //            wr    addr          len   rlast bresp rr stall rst dbase         rej resp  err beats
      dir[0]  = '{1'b1, 32'h0000_0100, 8'd3,  -1, 2'd0, 1'b0, 0, -1, 32'h11,        1'b0, 2'd0, 1'b0, 4};
      dir[1]  = '{1'b0, 32'hBABA_BAB8, 8'd0,  -1, 2'd0, 1'b0, 0, -1, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0, 1};
      dir[2]  = '{1'b0, 32'h0000_0000, 8'd7,  -1, 2'd0, 1'b0, 2, -1, 32'h1000_0000, 1'b0, 2'd0, 1'b0, 8};
      dir[3]  = '{1'b1, 32'h0000_0000, 8'd16, -1, 2'd0, 1'b0, 0, -1, 32'h0,         1'b1, 2'd2, 1'b1, 0};
      dir[4]  = '{1'b0, 32'h0000_0FFC, 8'd1,  -1, 2'd0, 1'b0, 0, -1, 32'h0,         1'b1, 2'd2, 1'b1, 0};
      dir[5]  = '{1'b0, 32'h0000_0200, 8'd3,   1, 2'd0, 1'b0, 0, -1, 32'h2000_0000, 1'b0, 2'd0, 1'b1, 2};
      dir[6]  = '{1'b1, 32'h0000_0300, 8'd1,  -1, 2'd2, 1'b0, 1, -1, 32'h300,       1'b0, 2'd2, 1'b0, 2};
      dir[7]  = '{1'b1, 32'h0000_0FC0, 8'd15, -1, 2'd0, 1'b0, 1, -1, 32'h700,       1'b0, 2'd0, 1'b0, 16};
      dir[8]  = '{1'b0, 32'h0000_0FC4, 8'd15, -1, 2'd0, 1'b0, 0, -1, 32'h0,         1'b1, 2'd2, 1'b1, 0};
      dir[9]  = '{1'b0, 32'h0000_0040, 8'd15, -1, 2'd0, 1'b0, 1, -1, 32'h9000_0000, 1'b0, 2'd0, 1'b0, 16};
      dir[10] = '{1'b0, 32'h0000_0080, 8'd2,  -2, 2'd0, 1'b0, 0, -1, 32'hA000_0000, 1'b0, 2'd0, 1'b1, 3};
      dir[11] = '{1'b1, 32'h0000_0400, 8'd3,  -1, 2'd0, 1'b0, 0,  2, 32'h400,       1'b0, 2'd0, 1'b0, 4};
      dir[12] = '{1'b1, 32'h0000_0500, 8'd3,  -1, 2'd1, 1'b0, 0, -1, 32'h500,       1'b0, 2'd1, 1'b0, 4};
      dir[13] = '{1'b0, 32'h0000_0000, 8'd255,-1, 2'd0, 1'b0, 0, -1, 32'h0,         1'b1, 2'd2, 1'b1, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_valids", {27'd0, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}, 0);
      chk("reset_done", {28'd0, done, done_err, done_resp}, 0);
      chk("reset_wr_ready", {31'd0, wr_ready}, 0);
      chk("reset_addr_len", m_axi_awaddr | {24'd0, m_axi_awlen}, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("reset_cmd_ready", {31'd0, cmd_ready}, 1);

      for (int i = 0; i < 14; i++) begin
         for (int k = 0; k < 256; k++) rresp_seq[k] = 2'b00;
         run(dir[i]);
      end

      for (int i = 0; i < 40; i++) begin
         v.write = 1'($urandom_range(0, 1));
         v.len   = 8'($urandom_range(0, 18));
         v.addr  = $urandom;
         if ($urandom_range(0, 3) == 0) v.addr[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
         case ($urandom_range(0, 5))
            0:       v.rlast_at = $urandom_range(0, int'(v.len));
            1:       v.rlast_at = -2;
            default: v.rlast_at = -1;
         endcase
         v.bresp = 2'($urandom_range(0, 3)); v.rresp_rand = 1'b1;
         v.stall = $urandom_range(1, 2); v.reset_at = -1; v.dbase = $urandom;
         for (int k = 0; k < 256; k++)
            rresp_seq[k] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run(model(v));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pb_axi_burst_master.md
Name: pb_axi_burst_master

Overview:
- AXI4 burst initiator for the packet-processing datapath.
- Packet builder/parser logic issues single read or write INCR bursts through a command port. Write data streams in; read data streams out.
- Mates with the AXI4 slave responder used by the formal environment and the memory model in the integration bench.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; only 32 is supported
MAX_BEATS, 16, maximum beats per burst; larger commands are rejected

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted on valid&ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start byte address; bits[1:0] ignored and forced to 0
cmd_len  in  8  beats-1
wr_data  in  DATA_W  write data stream
wr_valid  in  1  write data valid
wr_ready  out  1  write data consumed
rd_data  out  DATA_W  read data stream
rd_valid  out  1  read data valid
rd_last  out  1  last read beat
rd_ready  in  1  read data consumer ready
done  out  1  one-cycle pulse at burst end
done_resp  out  2  worst (max) BRESP/RRESP of the burst
done_err  out  1  rejected command or RLAST/beat-count mismatch
m_axi_aw*  out  awaddr[ADDR_W], awlen[8], awsize[3], awburst[2], awvalid; in awready
m_axi_w*  out  wdata[DATA_W], wstrb[4], wlast, wvalid; in wready
m_axi_b*  in  bresp[2], bvalid; out bready
m_axi_ar*  out  araddr[ADDR_W], arlen[8], arsize[3], arburst[2], arvalid; in arready
m_axi_r*  in  rdata[DATA_W], rresp[2], rlast, rvalid; out rready

Behaviour:
- Reset: state IDLE. All valids, bready, rready, done, done_err and wr_ready are 0. done_resp=0; address/len registers 0. cmd_ready=1 after reset deasserts.
- Constant outputs: awsize/arsize=3'b010, awburst/arburst=2'b01 (INCR), wstrb=4'hF.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE: cmd_ready=1 only in IDLE. On accept, latch addr/len/write and clear the beat counter and resp accumulator.
  - Reject if cmd_len >= MAX_BEATS, or if addr[11:0] + (len+1)*4 > 4096 (4KB crossing). A rejected command goes to DONE with done_err=1, done_resp=2'b10, and no bus activity.
  - Otherwise go to AW (write) or AR (read).
- AW/AR: awvalid/arvalid is registered, asserted the cycle after accept and held with stable addr/len until the ready handshake. Then go to W/R. valid never depends on ready.
- W: entered only after the AW handshake (no early write data).
  - Pass-through: wvalid=wr_valid, wdata=wr_data, wr_ready=wready; wr_ready is 0 in all other states.
  - wlast=(beat_cnt==len). beat_cnt increments on wvalid&wready.
  - Last handshake goes to B.
- B: bready=1. On bvalid, done_resp=bresp, then go to DONE.
- R: pass-through: rready=rd_ready, rd_valid=rvalid, rd_data=rdata, rd_last=rlast.
  - On each rvalid&rready, beat_cnt++ and done_resp=max(done_resp,rresp).
  - Burst ends on the beat where rlast=1 or beat_cnt==len, whichever comes first. If the two disagree, set done_err=1 and still go to DONE.
  - Extra beats arriving after the terminating beat are not the block's concern; the slave is assumed compliant.
- DONE: done=1 for exactly one cycle; done_resp/done_err valid with it and held until the next accept. Then go to IDLE.
- Latency: accept to awvalid/arvalid is 1 cycle. Final B/R handshake to done is 1 cycle. Back-to-back commands are possible with cmd_ready reasserting the cycle after done.
- Single outstanding transaction. Write and read never overlap.
- Reset mid-operation: all valids/ready drop the next cycle, any partial burst is abandoned, no done pulse.
- cmd_valid while busy is ignored (cmd_ready=0); the requester holds it.

Test Plan:
- Write addr=0x100, len=3, data 0x11..0x44 with wr_valid always high, zero-wait slave -> awaddr=0x100, awlen=3, 4 W beats with wlast on the 4th, bready; done one cycle after B with done_resp=0, done_err=0.
- Read addr=0xBABABAB8, len=0, slave returns 0xDEADBEEF with rlast=1 -> arlen=0, single rd_valid beat with rd_last=1, done_resp=0.
- Read len=7 with rd_ready toggling every cycle and slave rvalid gaps -> 8 beats delivered in order, rready mirrors rd_ready, no beat lost or duplicated.
- Commands len=16 (MAX_BEATS=16) and addr=0xFFC, len=1 -> no awvalid/arvalid; done with done_err=1, done_resp=2'b10.
- Read len=3 where the slave asserts rlast on beat 2; separate write with bresp=2'b10 -> done_err=1 for the first; done_resp=2'b10 for the second.
- Reset asserted during the W state after 2 of 4 beats -> next cycle wvalid=0, state IDLE, cmd_ready=1, no done; a new write then completes normally.
